cnn_line_delay_buf: RTL and testbench



---
 rtl/cnn_line_delay_buf.sv | 57 +++++
 tb/tb_cnn_line_delay_buf.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cnn_line_delay_buf.sv
// cnn_line_delay_buf: stallable line-delay buffer with runtime depth, per-stage valid and flush
module cnn_line_delay_buf #(
   parameter int DATA_W    = 128,
   parameter int MAX_DEPTH = 32,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [DEPTH_W-1:0] depth_cfg,
   input  logic               shift_en,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [DEPTH_W-1:0] active_depth,
   output logic               primed
);
   localparam int IDX_W = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
   localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
   logic [DATA_W:0]      stage [MAX_DEPTH];
   logic [DEPTH_W-1:0]   cnt;
   logic [DEPTH_W-1:0]   depth_clamped;
   logic [IDX_W-1:0]     tap;
   // clamp the requested depth into 1..MAX_DEPTH
   always_comb begin
      depth_clamped = depth_cfg == '0 ? DEPTH_W'(1) : depth_cfg > MAX_D ? MAX_D : depth_cfg;
   end
   // stage storage: flush clears, shift advances the whole line, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DEPTH; i++) stage[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < MAX_DEPTH; i++) stage[i] <= '0;
      end else if (shift_en) begin
         stage[0] <= {in_valid, in_data};
         for (int i = 1; i < MAX_DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   // depth register: only a flush may change it, so it is fixed mid-stream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) active_depth <= MAX_D;
      else if (flush) active_depth <= depth_clamped;
   end
   // saturating count of accepted shifts since reset/flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (flush) cnt <= '0;
      else if (shift_en && cnt < MAX_D) cnt <= cnt + DEPTH_W'(1);
   end
   // tap select and outputs, sourced only from registers
   always_comb begin
      tap = IDX_W'(active_depth - DEPTH_W'(1));
      {out_valid, out_data} = stage[tap];
      primed = cnt >= active_depth;
   end
endmodule

// File: tb/tb_cnn_line_delay_buf.sv
// tb_cnn_line_delay_buf: directed and random checks against a sample-history model
module tb_cnn_line_delay_buf;
   localparam int DW = 8;
   localparam int MD = 16;
   localparam int WW = $clog2(MD + 1);
   logic          clk = 0;
   logic          rst = 1;
   logic          flush = 0;
   logic [WW-1:0] depth_cfg = '0;
   logic          shift_en = 0;
   logic          in_valid = 0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [WW-1:0] active_depth;
   logic          primed;
   int            errors = 0;
   int            checks = 0;
   logic [DW:0]   hist [$];
   int            dep = MD;

   cnn_line_delay_buf #(.DATA_W(DW), .MAX_DEPTH(MD)) dut (
      .clk(clk), .rst(rst), .flush(flush), .depth_cfg(depth_cfg), .shift_en(shift_en),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
      .active_depth(active_depth), .primed(primed)
   );

   always #5 clk = ~clk;

   function automatic int clampd(input int dc);
      return dc < 1 ? 1 : dc > MD ? MD : dc;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // the delayed tap is simply the sample accepted dep shifts ago, or cleared if too few
   task automatic model_check();
      int n;
      logic [DW:0] e;
      n = hist.size();
      e = n >= dep ? hist[n-dep] : '0;
      chk("tap", {23'd0, out_valid, out_data}, {23'd0, e});
      chk("depth", 32'(active_depth), 32'(dep));
      chk("primed", 32'(primed), 32'(n >= dep));
   endtask

   task automatic step(input logic f, input int dc, input logic s, input logic v, input int d);
      flush = f;
      depth_cfg = WW'(dc);
      shift_en = s;
      in_valid = v;
      in_data = DW'(d);
      @(posedge clk);
      if (f) begin
         hist.delete();
         dep = clampd(dc);
      end else if (s) hist.push_back({v, DW'(d)});
      #1 model_check();
   endtask

   initial begin
      #12 rst = 0;
      chk("rst_data", 32'(out_data), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_depth", 32'(active_depth), MD);
      chk("rst_primed", 32'(primed), 0);
      // mid-stream async reset with 0x5A on the output
      step(1, 2, 0, 0, 0);
      step(0, 0, 1, 1, 'h5A);
      step(0, 0, 1, 1, 'h5B);
      chk("pre_rst_5a", 32'(out_data), 'h5A);
      #3 rst = 1;
      #1;
      chk("arst_data", 32'(out_data), 0);
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_depth", 32'(active_depth), MD);
      chk("arst_primed", 32'(primed), 0);
      hist.delete();
      dep = MD;
      #2 rst = 0;
      // depth 12 legacy behaviour
      step(1, 12, 0, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         step(0, 0, 1, 1, i);
         if (i == 11) chk("d12_not_yet", {30'd0, out_valid, primed}, 0);
         if (i == 12) chk("d12_first", {22'd0, out_valid, primed, out_data}, {22'd0, 2'b11, 8'h01});
         if (i > 12) chk("d12_incr", 32'(out_data), i - 11);
      end
      // stall holds outputs
      step(1, 4, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 'hA0 + i);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 'hEE);
         chk("stall_hold", 32'(out_data), 'hA0);
      end
      step(0, 0, 1, 1, 'hA4);
      chk("stall_resume", 32'(out_data), 'hA1);
      // clamp limits
      step(1, 0, 0, 0, 0);
      chk("clamp_lo", 32'(active_depth), 1);
      step(0, 0, 1, 1, 'h33);
      step(0, 0, 1, 1, 'h44);
      chk("bypass_lag", 32'(out_data), 'h44);
      step(1, 31, 0, 0, 0);
      chk("clamp_hi", 32'(active_depth), MD);
      // flush wins over shift; depth_cfg ignored without flush
      step(1, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 'h60 + i);
      step(1, 2, 1, 1, 'h77);
      chk("fl_prio", {29'd0, out_valid, primed, 1'b0} | 32'(active_depth) << 3, 32'd2 << 3);
      for (int i = 0; i < 6; i++) begin
         step(0, 9, 1, 1, 'h80 + i);
         chk("no_77", 32'(out_data == 8'h77), 0);
      end
      chk("cfg_ignored", 32'(active_depth), 2);
      // valid gaps
      step(1, 5, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, (i % 2) == 0, 'h10 + i);
         if (i == 5) chk("gap_11", {23'd0, out_valid, out_data}, {23'd0, 1'b0, 8'h11});
      end
      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(39) == 0, int'($urandom_range(31)), $urandom_range(3) != 0,
              1'($urandom), int'($urandom_range(255)));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
